// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// The master side drives operands and out_ready. The slave side is the multiplier.
interface fp_mult_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_operand;
  logic [W-1:0]     b_operand;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       flags;

  modport master (
    output in_valid, a_operand, b_operand, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flags
  );

  modport slave (
    input  in_valid, a_operand, b_operand, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flags
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack, multiply, normalise/round/pack.
// Defining FPMUL_RNE_EN selects round-to-nearest-even. Otherwise the result is truncated and overflow saturates.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  fp_mult_pipe_if.slave mul_io
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * MAN_W + 2;
  localparam int LZW = $clog2(PW + 1);
  localparam int EW2 = EXP_W + 2;
  localparam int EW3 = EXP_W + LZW + 2;
  localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW3-1:0] EXP_MAX  = EW3'((1 << EXP_W) - 1);
  localparam logic signed [EW3-1:0] EXP_ZERO = '0;

  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  logic             sign1_d, nan1_d, inf1_d, zero1_d;
  logic [SW-1:0]    sigA1_d, sigB1_d;
  logic [EXP_W-1:0] expA1_d, expB1_d;
  logic             sign1_q, nan1_q, inf1_q, zero1_q;
  logic [SW-1:0]    sigA1_q, sigB1_q;
  logic [EXP_W-1:0] expA1_q, expB1_q;
  logic [TAG_W-1:0] tag1_q;

  logic [PW-1:0]           prod2_d;
  logic signed [EW2-1:0]   exp2_d;
  logic                    sign2_q, nan2_q, inf2_q, zero2_q;
  logic [PW-1:0]           prod2_q;
  logic signed [EW2-1:0]   exp2_q;
  logic [TAG_W-1:0]        tag2_q;

  logic [W-1:0]     result_d, result_q;
  logic [4:0]       flags_d, flags_q;
  logic [TAG_W-1:0] outTag_q;

  logic [EXP_W-1:0] expA, expB;
  logic [MAN_W-1:0] manA, manB;
  logic             zeroA, zeroB, infA, infB, nanA, nanB;

  // A stage loads when it is empty or its successor is loading, so bubbles collapse under stall.
  assign ld3 = !v3_q || mul_io.out_ready;
  assign ld2 = !v2_q || ld3;
  assign ld1 = !v1_q || ld2;

  assign mul_io.in_ready  = ld1;
  assign mul_io.out_valid = v3_q;
  assign mul_io.result    = result_q;
  assign mul_io.out_tag   = outTag_q;
  assign mul_io.flags     = flags_q;

  assign {expA, manA} = mul_io.a_operand[W-2:0];
  assign {expB, manB} = mul_io.b_operand[W-2:0];

  always_comb begin
    zeroA   = (expA == '0) && (manA == '0);
    zeroB   = (expB == '0) && (manB == '0);
    infA    = (expA == '1) && (manA == '0);
    infB    = (expB == '1) && (manB == '0);
    nanA    = (expA == '1) && (manA != '0);
    nanB    = (expB == '1) && (manB != '0);
    sign1_d = mul_io.a_operand[W-1] ^ mul_io.b_operand[W-1];
    nan1_d  = nanA || nanB || (infA && zeroB) || (zeroA && infB);
    inf1_d  = (infA || infB) && !nan1_d;
    zero1_d = (zeroA || zeroB) && !nan1_d && !inf1_d;
    // A subnormal operand has no hidden bit and uses exponent 1.
    sigA1_d = {(expA != '0), manA};
    sigB1_d = {(expB != '0), manB};
    expA1_d = (expA == '0) ? EXP_W'(1) : expA;
    expB1_d = (expB == '0) ? EXP_W'(1) : expB;
  end

  always_comb begin
    prod2_d = PW'(sigA1_q) * PW'(sigB1_q);
    exp2_d  = $signed(EW2'(expA1_q)) + $signed(EW2'(expB1_q)) - BIAS;
  end

  logic [LZW-1:0]        lzc;
  logic [PW-2:0]         prodNorm;
  logic [MAN_W-1:0]      mant;
  logic                  guard, sticky, roundUp;
  logic [MAN_W:0]        mantRnd;
  logic signed [EW3-1:0] expNorm;

  // The leading one is moved to bit PW-1 and then dropped. Its exponent weight is 2^1 relative to exp2_q.
  always_comb begin
    lzc = LZW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (prod2_q[i]) lzc = LZW'(PW - 1 - i);
    end
    prodNorm = (PW-1)'(prod2_q << lzc);
    mant     = prodNorm[PW-2 -: MAN_W];
    guard    = prodNorm[MAN_W];
    sticky   = |prodNorm[MAN_W-1:0];
`ifdef FPMUL_RNE_EN
    roundUp  = guard && (sticky || mant[0]);
`else
    roundUp  = 1'b0;
`endif
    mantRnd  = {1'b0, mant} + {{MAN_W{1'b0}}, roundUp};
    expNorm  = EW3'(exp2_q) + EW3'(1) - EW3'(lzc) + EW3'(mantRnd[MAN_W]);
  end

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    if (nan2_q) begin
      result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d  = 5'b10000;
    end else if (inf2_q) begin
      result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero2_q) begin
      result_d = {sign2_q, {(W-1){1'b0}}};
      flags_d  = 5'b00010;
    end else if (expNorm >= EXP_MAX) begin
`ifdef FPMUL_RNE_EN
      result_d = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      result_d = {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
      flags_d  = 5'b01001;
    end else if (expNorm <= EXP_ZERO) begin
      result_d = {sign2_q, {(W-1){1'b0}}};
      flags_d  = 5'b00111;
    end else begin
      result_d = {sign2_q, expNorm[EXP_W-1:0], mantRnd[MAN_W-1:0]};
      flags_d  = {4'b0000, guard || sticky};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      result_q <= '0;
      outTag_q <= '0;
      flags_q  <= '0;
    end else begin
      if (ld1) v1_q <= mul_io.in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld3 && v2_q) begin
        result_q <= result_d;
        outTag_q <= tag2_q;
        flags_q  <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && mul_io.in_valid) begin
      sign1_q <= sign1_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      zero1_q <= zero1_d;
      sigA1_q <= sigA1_d;
      sigB1_q <= sigB1_d;
      expA1_q <= expA1_d;
      expB1_q <= expB1_d;
      tag1_q  <= mul_io.in_tag;
    end
    if (ld2 && v1_q) begin
      sign2_q <= sign1_q;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      zero2_q <= zero1_q;
      prod2_q <= prod2_d;
      exp2_q  <= exp2_d;
      tag2_q  <= tag1_q;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe at single and half precision.
// The expected values follow FPMUL_RNE_EN when it is defined.
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   testCount = 0;
  int   failCount = 0;
  int   inIdx;
  int   outIdx;
  logic fireIn;
  logic fireOut;

  logic [31:0] streamA [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] streamP [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                               32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) busF ();
  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) busH ();

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dutF (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_io (busF.slave)
  );

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dutH (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_io (busH.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    @(negedge clk);
    busF.a_operand = a;
    busF.b_operand = b;
    busF.in_tag    = tag;
    busF.in_valid  = 1'b1;
    #1;
    checkOutput({name, " in_ready"}, 32'(busF.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    busF.in_valid = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] expResult, input logic [4:0] expFlags);
    applyStimulus(name, a, b, tag);
    checkOutput({name, " valid c1"}, 32'(busF.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, " valid c2"}, 32'(busF.out_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, " valid c3"}, 32'(busF.out_valid), 32'd1);
    checkOutput({name, " result"}, busF.result, expResult);
    checkOutput({name, " flags"}, 32'(busF.flags), 32'(expFlags));
    checkOutput({name, " tag"}, 32'(busF.out_tag), 32'(tag));
  endtask

  initial begin
    rst_n          = 1'b0;
    busF.in_valid  = 1'b0;
    busF.a_operand = '0;
    busF.b_operand = '0;
    busF.in_tag    = '0;
    busF.out_ready = 1'b1;
    busH.in_valid  = 1'b0;
    busH.a_operand = '0;
    busH.b_operand = '0;
    busH.in_tag    = '0;
    busH.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset out_valid", 32'(busF.out_valid), 32'd0);
    checkOutput("reset result", busF.result, 32'd0);
    checkOutput("reset out_tag", 32'(busF.out_tag), 32'd0);
    checkOutput("reset flags", 32'(busF.flags), 32'd0);
    checkOutput("reset in_ready", 32'(busF.in_ready), 32'd1);
    checkOutput("reset half out_valid", 32'(busH.out_valid), 32'd0);

    runOp("3x2", 32'h40400000, 32'h40000000, 4'h1, 32'h40C00000, 5'b00000);
    runOp("1.5x1.5", 32'h3FC00000, 32'h3FC00000, 4'h2, 32'h40100000, 5'b00000);
`ifdef FPMUL_RNE_EN
    runOp("tie", 32'h3F800001, 32'h3FC00000, 4'h3, 32'h3FC00002, 5'b00001);
    runOp("overflow", 32'h7F000000, 32'h7F000000, 4'h4, 32'h7F800000, 5'b01001);
`else
    runOp("tie", 32'h3F800001, 32'h3FC00000, 4'h3, 32'h3FC00001, 5'b00001);
    runOp("overflow", 32'h7F000000, 32'h7F000000, 4'h4, 32'h7F7FFFFF, 5'b01001);
`endif
    runOp("inf x zero", 32'h7F800000, 32'h00000000, 4'h5, 32'h7FC00000, 5'b10000);
    runOp("-inf x 2", 32'hFF800000, 32'h40000000, 4'h6, 32'hFF800000, 5'b00000);
    runOp("nan x 1", 32'h7FC12345, 32'h3F800000, 4'h7, 32'h7FC00000, 5'b10000);
    runOp("underflow", 32'h00800000, 32'h00800000, 4'h8, 32'h00000000, 5'b00111);
    runOp("-0 x 2", 32'h80000000, 32'h40000000, 4'h9, 32'h80000000, 5'b00010);

    // Tagged stream under random backpressure. Results must arrive in order and hold while stalled.
    inIdx  = 0;
    outIdx = 0;
    for (int cyc = 0; cyc < 300 && outIdx < 8; cyc++) begin
      @(negedge clk);
      busF.out_ready = 1'($urandom_range(0, 1));
      busF.in_valid  = (inIdx < 8);
      if (inIdx < 8) begin
        busF.a_operand = streamA[inIdx];
        busF.b_operand = 32'h40000000;
        busF.in_tag    = 4'(inIdx);
      end
      #1;
      if (busF.out_valid) begin
        if (outIdx < 8) begin
          checkOutput("stream result", busF.result, streamP[outIdx]);
          checkOutput("stream tag", 32'(busF.out_tag), 32'(outIdx));
          checkOutput("stream flags", 32'(busF.flags), 32'd0);
        end else begin
          checkOutput("stream extra valid", 32'(busF.out_valid), 32'd0);
        end
      end
      fireIn  = busF.in_valid && busF.in_ready;
      fireOut = busF.out_valid && busF.out_ready;
      @(posedge clk);
      if (fireIn) inIdx++;
      if (fireOut) outIdx++;
    end
    @(negedge clk);
    busF.in_valid  = 1'b0;
    busF.out_ready = 1'b1;
    checkOutput("stream count", 32'(outIdx), 32'd8);
    checkOutput("stream drained", 32'(busF.out_valid), 32'd0);

    // Three operations in flight when reset hits. None of them may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      busF.a_operand = 32'h40400000;
      busF.b_operand = 32'h40000000;
      busF.in_tag    = 4'(10 + i);
      busF.in_valid  = 1'b1;
    end
    @(negedge clk);
    busF.in_valid = 1'b0;
    checkOutput("pre-reset valid", 32'(busF.out_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset out_valid", 32'(busF.out_valid), 32'd0);
    checkOutput("midreset in_ready", 32'(busF.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post-reset no stale", 32'(busF.out_valid), 32'd0);
    end

    // Half precision: 1.0 x -2.0.
    @(negedge clk);
    busH.a_operand = 16'h3C00;
    busH.b_operand = 16'hC000;
    busH.in_tag    = 4'h5;
    busH.in_valid  = 1'b1;
    #1;
    checkOutput("half in_ready", 32'(busH.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    busH.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("half valid", 32'(busH.out_valid), 32'd1);
    checkOutput("half result", 32'(busH.result), 32'h0000C000);
    checkOutput("half flags", 32'(busH.flags), 32'd0);
    checkOutput("half tag", 32'(busH.out_tag), 32'd5);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides. It generalises the team's combinational single-precision multiplier in three ways: configurable exponent and mantissa widths, a three-stage pipeline with full backpressure, and correct special-value handling (NaN, Inf, Inf×0, subnormal inputs) with a sticky-free per-result flag bundle. It sits between operand-fetch logic and any FP consumer (accumulator, writeback) in the datapath.

## Interface
- EXP_W, 8, exponent field width (≥4)
- MAN_W, 23, stored mantissa width, hidden bit excluded (≥4)
- TAG_W, 4, width of the user tag carried alongside each operation (≥1)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts the operand pair this cycle
- a_operand  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b_operand  input  1+EXP_W+MAN_W  operand B
- in_tag  input  TAG_W  opaque tag, returned with the result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  1+EXP_W+MAN_W  product
- out_tag  output  TAG_W  tag of this result
- flags  output  5  {invalid, overflow, underflow, zero, inexact}

## Operation
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Stage 1 (unpack): sign = sA^sB; classify each operand as zero, subnormal, normal, Inf, NaN. Subnormal: hidden bit 0, effective exponent 1. Normal: hidden bit 1.
- Stage 2 (multiply): (MAN_W+1)×(MAN_W+1) significand product, 2·MAN_W+2 bits; exponent sum eA+eB−BIAS in signed EXP_W+2 bits, BIAS = 2^(EXP_W−1)−1.
- Stage 3 (normalise/round/pack): if product MSB set, shift right 1 and increment exponent; otherwise left-shift by leading-zero count (subnormal inputs) and decrement exponent accordingly. Guard bit and sticky (OR of all lower bits) form the rounding decision; mantissa carry-out on rounding increments exponent and renormalises.
- Result priority: NaN operand or Inf×0 → canonical qNaN {0, all-ones exp, 1, zeros}, invalid=1. Inf × nonzero → signed Inf. Zero × finite → signed zero, zero=1. Final exponent ≥ all-ones → signed Inf, overflow=1, inexact=1. Final exponent ≤ 0 → flush to signed zero, underflow=1, zero=1, inexact=1 if any bit nonzero (no subnormal outputs). Otherwise packed normal; inexact = guard|sticky.
- Flags belong to that result only; no sticky accumulation.
- Tag travels unmodified with its operation.

## Timing
- Latency 3 cycles accept-to-out_valid when out_ready held high; throughput 1/cycle.
- Each stage has its own valid bit. Stage advances when downstream stage is empty or advancing; in_ready = !v1 | advance1 (combinational from out_ready through the chain, no registered skid).
- Stall (out_ready=0 with out_valid=1): result, out_tag, flags held stable; no operation lost or duplicated; bubbles ahead of the stall collapse.
- out_valid never depends combinationally on out_ready.
- Reset (rst_n=0 at clk edge): all stage valids 0; out_valid=0, result=0, out_tag=0, flags=0; in_ready=1 from first cycle after reset release. Reset mid-operation discards all in-flight operations; no result emerges for them.
- Data registers need no reset beyond outputs listed.

## Configuration
- FPMUL_RNE_EN defined: round to nearest, ties to even (increment if guard & (sticky | lsb)).
- FPMUL_RNE_EN undefined: truncation (round toward zero); overflow then saturates to max finite {sign, all-ones−1, all-ones} instead of Inf; inexact still reported.

## Test plan
- Default widths: 0x40400000 × 0x40000000 → 0x40C00000, flags 0, 3 cycles after accept; 0x3FC00000 × 0x3FC00000 → 0x40100000.
- Tie: 0x3F800001 × 0x3FC00000 → 0x3FC00002 inexact=1 (RNE); 0x3FC00001 inexact=1 (truncate).
- Specials: 0x7F800000 × 0x00000000 → 0x7FC00000 invalid=1; 0xFF800000 × 0x40000000 → 0xFF800000; 0x7F000000 × 0x7F000000 → 0x7F800000 overflow=1 (RNE build); 0x00800000 × 0x00800000 → 0x00000000 underflow=1 zero=1.
- Backpressure: stream 8 tagged ops back-to-back, toggle out_ready randomly → 8 results in order, tags 0..7, held stable while stalled.
- Reset mid-flight: accept 3 ops, pull rst_n low one cycle → out_valid=0 next cycle, no stale results afterward, in_ready=1.
- EXP_W=5, MAN_W=10 (half): 0x3C00 × 0xC000 → 0xC000 (1.0 × −2.0).
